// File: rtl/operand_loader_pkg.sv
// Shared definitions for the operand loader: FSM states, button indices,
// control-word field positions and the button-pattern helper.
package operand_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRESS,
    LOAD,
    HOLD,
    RELEASE
  } state_t;

  localparam int BTN_A = 0;
  localparam int BTN_B = 1;
  localparam int BTN_C = 2;

  localparam int C_W = 10;

  // C_reg field layout consumed by the ALU/display top.
  localparam int HEX_MODE_MSB = 9;
  localparam int HEX_MODE_LSB = 8;
  localparam int HEX_SHOW_MSB = 7;
  localparam int HEX_SHOW_LSB = 6;
  localparam int LED_SHOW_MSB = 5;
  localparam int LED_SHOW_LSB = 4;
  localparam int CARRY_IN     = 3;
  localparam int ALU_OP_MSB   = 2;
  localparam int ALU_OP_LSB   = 0;

  function automatic logic is_single(input logic [2:0] btn);
    return (btn == 3'b001) || (btn == 3'b010) || (btn == 3'b100);
  endfunction

endpackage

// File: rtl/operand_loader_sync2.sv
// Parameterized-width two-flop synchronizer for asynchronous switch and
// button inputs; asynchronous active-high reset clears both stages.
module sync2 #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_meta;
  logic [W-1:0] r_sync;

  // NOTE: non-blocking assignments make r_sync take the old r_meta, giving two real stages.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/operand_loader.sv
// Debounced loader capturing SWITCH into the A/B/C operand registers on button presses.
// Optional CLEAR_COMBO_EN: a debounced three-button press clears all registers.
module operand_loader
  import operand_loader_pkg::*;
#(
  parameter int N          = 10,
  parameter int DEB_CYCLES = 500000
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [C_W-1:0] SWITCH,
  input  logic           B0,
  input  logic           B1,
  input  logic           B2,
  output logic [N-1:0]   A_reg,
  output logic [N-1:0]   B_reg,
  output logic [C_W-1:0] C_reg,
  output logic [2:0]     load_pulse,
  output logic           busy
);

  localparam int                CNT_W   = $clog2(DEB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [C_W-1:0]   w_sw;
  logic [2:0]       w_btn;
  logic             w_none;
  logic             w_press_ok;
  logic             w_clear;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_cnt_done;

  state_t           r_state;
  logic [2:0]       r_cand;
  logic [CNT_W-1:0] r_cnt;
  logic [N-1:0]     r_a;
  logic [N-1:0]     r_b;
  logic [C_W-1:0]   r_c;
  logic [2:0]       r_load_pulse;
  logic             r_busy;

  sync2 #(.W(C_W)) u_sync_sw (
    .clk (clk),
    .rst (rst),
    .i_d (SWITCH),
    .o_q (w_sw)
  );

  sync2 #(.W(3)) u_sync_btn (
    .clk (clk),
    .rst (rst),
    .i_d ({B2, B1, B0}),
    .o_q (w_btn)
  );

  assign w_none = (w_btn == 3'b000);

`ifdef CLEAR_COMBO_EN
  assign w_press_ok = is_single(w_btn) || (w_btn == 3'b111);
  assign w_clear    = (r_cand == 3'b111);
`else
  assign w_press_ok = is_single(w_btn);
  assign w_clear    = 1'b0;
`endif

  // Saturating increment; the FSM leaves the counting state on reaching DEB_CYCLES.
  assign w_cnt_inc  = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_ONE;
  assign w_cnt_done = (w_cnt_inc == CNT_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_cand       <= '0;
      r_cnt        <= '0;
      r_a          <= '0;
      r_b          <= '0;
      r_c          <= '0;
      r_load_pulse <= '0;
      r_busy       <= 1'b0;
    end else begin
      r_load_pulse <= '0;
      case (r_state)
        IDLE: begin
          if (w_press_ok) begin
            r_state <= PRESS;
            r_cand  <= w_btn;
            r_cnt   <= CNT_ONE;
            r_busy  <= 1'b1;
          end
        end
        PRESS: begin
          if (w_btn == r_cand) begin
            r_cnt <= w_cnt_inc;
            if (w_cnt_done) begin
              r_state      <= LOAD;
              r_load_pulse <= r_cand;
            end
          end else begin
            // Bounce, early release or a second button all restart debouncing.
            r_state <= IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
          end
        end
        LOAD: begin
          if (w_clear) begin
            r_a <= '0;
            r_b <= '0;
            r_c <= '0;
          end else begin
            if (r_cand[BTN_A]) r_a <= w_sw[N-1:0];
            if (r_cand[BTN_B]) r_b <= w_sw[N-1:0];
            if (r_cand[BTN_C]) r_c <= w_sw;
          end
          r_state <= HOLD;
        end
        HOLD: begin
          if (w_none) begin
            r_state <= RELEASE;
            r_cnt   <= CNT_ONE;
          end
        end
        RELEASE: begin
          if (w_none) begin
            r_cnt <= w_cnt_inc;
            if (w_cnt_done) begin
              r_state <= IDLE;
              r_cnt   <= '0;
              r_busy  <= 1'b0;
            end
          end else begin
            r_state <= HOLD;
            r_cnt   <= '0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign A_reg      = r_a;
  assign B_reg      = r_b;
  assign C_reg      = r_c;
  assign load_pulse = r_load_pulse;
  assign busy       = r_busy;

endmodule
